sseg_scan_driver: RTL

// Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.

---
 rtl/sseg_pkg.sv | 32 +++
 rtl/sseg_hex_encoder.sv | 11 +
 rtl/sseg_scan_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and hex-to-segment decoding for the 7-segment scan driver.
// Segment vectors are active-high internally, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
    seg7_t s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational nibble to active-high 7-segment pattern.
module sseg_hex_encoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow/display double buffering,
// frame-aligned updates, leading-zero blanking and anti-ghost slot blanking.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             LZ_CFG    = (LZ_BLANK != 0);

  // XOR masks that convert active-high internal values to pin polarity.
  localparam seg7_t                 SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic                    lz_on;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   onehot;
  seg7_t                   enc_seg;
  logic                    in_blank;

  logic [6:0]              seg_p0;
  logic                    dp_p0;
  logic [NUM_DIGITS-1:0]   dig_p0;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign lz_on     = LZ_CFG && lz_en;
  assign in_blank  = (BLANK_CYCLES > 0) && (cnt < BLANK_END);

  // Stage 0: slot timing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A load in the boundary cycle lands in the shadow after the old shadow
  // has been copied, so it waits for the following boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Walk from the top digit down so zero_run means "this and all higher nibbles are zero".
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        cur_nib   = disp_val[4*k +: 4];
        cur_dp    = disp_dp[k];
        onehot[k] = 1'b1;
        cur_blank = lz_on && zero_run && (k != 0);
      end
    end
  end

  sseg_hex_encoder u_enc (
    .nibble (cur_nib),
    .seg    (enc_seg)
  );

  always_comb begin
    seg_p0 = SEG_BLANK ^ SEG_POL;
    dp_p0  = DP_POL;
    dig_p0 = DIG_POL;
    if (!in_blank) begin
      seg_p0 = (cur_blank ? SEG_BLANK : enc_seg) ^ SEG_POL;
      dp_p0  = cur_dp ^ DP_POL;
      dig_p0 = onehot ^ DIG_POL;
    end
  end

  // Stage 1: registered pin drivers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg    <= SEG_BLANK ^ SEG_POL;
      dp     <= DP_POL;
      dig_en <= DIG_POL;
    end else begin
      seg    <= seg_p0;
      dp     <= dp_p0;
      dig_en <= dig_p0;
    end
  end

endmodule
